// File: rtl/multi_dma_bus_arbiter.sv
// Arbitrates CPU bus ownership among NCH DMA channels via the busrq_n/busak_n
// handshake, with round-robin winner selection, burst limiting and a CPU gap.
module multi_dma_bus_arbiter #(
  parameter int NCH      = 2,
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int MAXBURST = 64,
  parameter int CPUGAP   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     cpu_a,
  input  logic [DW-1:0]     cpu_dout,
  input  logic              cpu_mreq_n,
  input  logic              cpu_iorq_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_wr_n,
  input  logic              cpu_m1_n,
  input  logic              busak_n,
  output logic              busrq_n,
  input  logic [NCH-1:0]    ch_req,
  output logic [NCH-1:0]    ch_grant,
  input  logic [NCH*AW-1:0] ch_a,
  input  logic [NCH*DW-1:0] ch_dout,
  input  logic [NCH-1:0]    ch_mreq_n,
  input  logic [NCH-1:0]    ch_iorq_n,
  input  logic [NCH-1:0]    ch_rd_n,
  input  logic [NCH-1:0]    ch_wr_n,
  output logic [AW-1:0]     A,
  output logic [DW-1:0]     dout,
  output logic              mreq_n,
  output logic              iorq_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              m1_n,
  output logic [2:0]        owner
);

  localparam int BW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
  localparam int GW = (CPUGAP > 0) ? $clog2(CPUGAP + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

  state_t        state;
  logic [2:0]    rr_ptr;
  logic [BW-1:0] burst_cnt;
  logic [GW-1:0] gap_cnt;

  logic [7:0]    req8;
  logic          any_req;
  logic          burst_done;
  logic [3:0]    scan_idx;
  logic          found;
  logic [2:0]    winner;
  logic [3:0]    owner_inc;
  logic [2:0]    rr_next;

  logic [AW-1:0] ch_a_arr    [NCH];
  logic [DW-1:0] ch_dout_arr [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_slice
      assign ch_a_arr[gi]    = ch_a[gi*AW +: AW];
      assign ch_dout_arr[gi] = ch_dout[gi*DW +: DW];
    end
  endgenerate

  // Zero-extended copy so 3-bit channel indices select cleanly for any NCH.
  assign req8       = 8'(ch_req);
  assign any_req    = |ch_req;
  assign burst_done = (MAXBURST != 0) && (burst_cnt == BW'(MAXBURST - 1));
  assign owner_inc  = {1'b0, owner} + 4'd1;
  assign rr_next    = (owner_inc >= 4'(NCH)) ? 3'd0 : owner_inc[2:0];

  always_comb begin
    winner   = rr_ptr;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = {1'b0, rr_ptr} + 4'(k);
      if (scan_idx >= 4'(NCH)) scan_idx = scan_idx - 4'(NCH);
      if (!found && req8[scan_idx[2:0]]) begin
        winner = scan_idx[2:0];
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busrq_n   <= 1'b1;
      ch_grant  <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
          if (any_req && gap_cnt == '0) begin
            state   <= REQ;
            busrq_n <= 1'b0;
          end
        end
        REQ: begin
          if (!busak_n) begin
            if (any_req) begin
              state     <= GRANT;
              ch_grant  <= NCH'(1) << winner;
              owner     <= winner;
              burst_cnt <= '0;
            end else begin
              state   <= RELEASE;
              busrq_n <= 1'b1;
            end
          end
        end
        GRANT: begin
          burst_cnt <= burst_cnt + BW'(1);
          // Owner keeps the bus until it lets go or hits the burst limit.
          if (!req8[owner] || burst_done) begin
            state    <= RELEASE;
            ch_grant <= '0;
            busrq_n  <= 1'b1;
            owner    <= '0;
            rr_ptr   <= rr_next;
          end
        end
        RELEASE: begin
          if (busak_n) begin
            state   <= IDLE;
            gap_cnt <= GW'(CPUGAP);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    A      = cpu_a;
    dout   = cpu_dout;
    mreq_n = cpu_mreq_n;
    iorq_n = cpu_iorq_n;
    rd_n   = cpu_rd_n;
    wr_n   = cpu_wr_n;
    m1_n   = cpu_m1_n;
    if (!busak_n) begin
      A      = '0;
      dout   = '0;
      mreq_n = 1'b1;
      iorq_n = 1'b1;
      rd_n   = 1'b1;
      wr_n   = 1'b1;
      m1_n   = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (ch_grant[i]) begin
          A      = ch_a_arr[i];
          dout   = ch_dout_arr[i];
          mreq_n = ch_mreq_n[i];
          iorq_n = ch_iorq_n[i];
          rd_n   = ch_rd_n[i];
          wr_n   = ch_wr_n[i];
        end
      end
    end
  end

endmodule
